// File: rtl/spi_mode_pkg.sv
// Shared SPI mode encoding and transfer geometry.
// Imported by spi_master and spi_master_clkgen.
package spi_mode_pkg;

  typedef enum logic [1:0] {
    SMODE0 = 2'd0,
    SMODE1 = 2'd1,
    SMODE2 = 2'd2,
    SMODE3 = 2'd3
  } spi_mode_e;

  localparam int unsigned SPI_BITS    = 8;
  localparam int unsigned SPI_TOGGLES = 2 * SPI_BITS;

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCLK divider: level, leading/trailing toggle strobes and
// toggle count for spi_master.
module spi_master_clkgen
  import spi_mode_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       run_i,
  input  logic       xfer_i,
  input  logic       idle_i,
  input  logic       cpol_i,
  output logic       sclk_o,
  output logic       tick_o,
  output logic       lead_o,
  output logic       trail_o,
  output logic [4:0] tog_o
);

  logic [7:0] div_q;
  logic [4:0] tog_q;
  logic       sclk_q;

  assign tick_o  = run_i && (div_q == 8'(CLK_DIV - 1));
  assign lead_o  = tick_o && xfer_i && !tog_q[0];
  assign trail_o = tick_o && xfer_i && tog_q[0];
  assign sclk_o  = sclk_q;
  assign tog_o   = tog_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      tog_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (clr_i) begin
        div_q <= '0;
        tog_q <= '0;
      end else if (run_i) begin
        div_q <= tick_o ? 8'd0 : div_q + 8'd1;
        if (lead_o || trail_o)
          tog_q <= tog_q + 5'd1;
      end
      // idle level follows the live mode so a mode change shows at once
      if (idle_i)
        sclk_q <= cpol_i;
      else if (lead_o || trail_o)
        sclk_q <= ~sclk_q;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, modes 0..3, MSB first.
// Receive path built only when SPI_MASTER_RX_EN is defined.
module spi_master
  import spi_mode_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  spi_mode_e  M_STATE,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       SCLK,
  output logic       MOSI,
  output logic       SS,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE
  } state_e;

  state_e     state_q;
  spi_mode_e  mode_q;
  logic [7:0] sh_q;
  logic       mosi_q;
  logic       ss_q;
  logic       done_q;

  logic       tick, lead, trail;
  logic [4:0] tog;
  logic       accept, run, xfer, idle;
  logic       cpha, last;

  assign idle   = (state_q == IDLE);
  assign xfer   = (state_q == TRANSFER);
  assign run    = (state_q inside {SETUP, TRANSFER, HOLD});
  assign accept = idle && start;
  assign cpha   = mode_cpha(mode_q);
  assign last   = (tog == 5'(SPI_TOGGLES - 1));

  spi_master_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (accept),
    .run_i  (run),
    .xfer_i (xfer),
    .idle_i (idle),
    .cpol_i (mode_cpol(M_STATE)),
    .sclk_o (SCLK),
    .tick_o (tick),
    .lead_o (lead),
    .trail_o(trail),
    .tog_o  (tog)
  );

  assign ready = idle;
  assign done  = done_q;
  assign MOSI  = mosi_q;
  assign SS    = ss_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= SMODE0;
      sh_q    <= '0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ss_q   <= !run;
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          mosi_q <= 1'b0;
          if (start) begin
            state_q <= SETUP;
            mode_q  <= M_STATE;
            sh_q    <= tx_data;
            mosi_q  <= tx_data[7];
          end
        end
        SETUP: begin
          if (tick)
            state_q <= TRANSFER;
        end
        TRANSFER: begin
          // CPHA=1 re-presents bit 7 on the first lead, then shifts
          if (cpha) begin
            if (lead) begin
              mosi_q <= sh_q[7];
              sh_q   <= {sh_q[6:0], 1'b0};
            end
          end else if (trail && !last) begin
            mosi_q <= sh_q[6];
            sh_q   <= {sh_q[6:0], 1'b0};
          end
          if (trail && last)
            state_q <= HOLD;
        end
        HOLD: begin
          if (tick)
            state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [7:0] rsh_q;
  logic [7:0] rx_q;
  logic       sample;

  assign sample  = cpha ? trail : lead;
  assign rx_data = rx_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsh_q <= '0;
      rx_q  <= '0;
    end else begin
      if (accept)
        rsh_q <= '0;
      else if (sample)
        rsh_q <= {rsh_q[6:0], MISO};
      if (state_q == DONE)
        rx_q <= rsh_q;
    end
  end
`else
  logic unused_miso;

  assign unused_miso = MISO;
  assign rx_data     = 8'h00;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master.
// Expected rx depends on whether SPI_MASTER_RX_EN is defined.
module tb_spi_master;
  import spi_mode_pkg::*;

  localparam int unsigned D = 4;
  localparam int LAT = 18 * D + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  spi_mode_e  mode  = SMODE0;
  logic [7:0] tx    = 8'h00;
  logic [1:0] msel  = 2'd0;
  logic       MISO;
  logic       ready, done, SCLK, MOSI, SS;
  logic [7:0] rx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         mon_tog  = 0;
  int         mon_ss   = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_cpha = 1'b0;
  logic       sclk_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign MISO = (msel == 2'd0) ? MOSI :
                (msel == 2'd1) ? ~MOSI :
                (msel == 2'd2) ? 1'b0 : 1'b1;

  spi_master #(.CLK_DIV(D)) dut (
    .clock  (clk),
    .reset  (rst_n),
    .M_STATE(mode),
    .start  (start),
    .tx_data(tx),
    .ready  (ready),
    .done   (done),
    .rx_data(rx),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .SS     (SS),
    .MISO   (MISO)
  );

  // Bus monitor: counts SCLK toggles while selected and collects
  // MOSI at each toggle where the slave would sample.
  always @(posedge clk) begin
    #1;
    if (SS === 1'b0) begin
      mon_ss++;
      if (SCLK !== sclk_prev) begin
        mon_tog++;
        if (mon_tog[0] != mon_cpha)
          mon_byte = {mon_byte[6:0], MOSI};
      end
    end
    sclk_prev = SCLK;
  end

  function automatic logic [7:0] exp_rx(input logic [7:0] b,
                                        input logic [1:0] s);
`ifdef SPI_MASTER_RX_EN
    case (s)
      2'd0:    return b;
      2'd1:    return ~b;
      2'd2:    return 8'h00;
      default: return 8'hFF;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  task automatic start_xfer(input spi_mode_e m,
                            input logic [7:0] b,
                            input logic [1:0] s,
                            output int acc);
    @(negedge clk);
    mode = m; tx = b; msel = s;
    mon_cpha = m[0];
    mon_tog = 0; mon_ss = 0; mon_byte = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(output int dc, output bit tmo);
    int n;
    n = 0; tmo = 1'b1; dc = 0;
    while (tmo && n < 40 * D) begin
      if (done === 1'b1) begin
        dc = cyc; tmo = 1'b0;
      end else begin
        @(negedge clk); n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = SMODE2;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got %b exp 1", ready); end
    checks++;
    if (SS !== 1'b1) begin errors++;
      $display("FAIL rst_ss got %b exp 1", SS); end
    checks++;
    if (SCLK !== 1'b0) begin errors++;
      $display("FAIL rst_sclk got %b exp 0", SCLK); end
    checks++;
    if (MOSI !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL rst_mosi_done got %b%b exp 00", MOSI, done); end
    checks++;
    if (rx !== 8'h00) begin errors++;
      $display("FAIL rst_rx got %h exp 00", rx); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (SCLK !== 1'b1) begin errors++;
      $display("FAIL rel_cpol got %b exp 1", SCLK); end
  endtask

  task automatic test_mode0_loop();
    int a, d; bit t; logic [7:0] r;
    start_xfer(SMODE0, 8'hA5, 2'd0, a);
    wait_done(d, t);
    checks++;
    if (t) begin errors++;
      $display("FAIL m0_timeout got none exp done"); end
    checks++;
    if (d - a !== LAT) begin errors++;
      $display("FAIL m0_lat got %0d exp %0d", d - a, LAT); end
    checks++;
    if (mon_byte !== 8'hA5) begin errors++;
      $display("FAIL m0_mosi got %h exp a5", mon_byte); end
    checks++;
    if (mon_tog !== 16) begin errors++;
      $display("FAIL m0_tog got %0d exp 16", mon_tog); end
    checks++;
    if (mon_ss !== 18 * D) begin errors++;
      $display("FAIL m0_ss got %0d exp %0d", mon_ss, 18 * D); end
    r = exp_rx(8'hA5, 2'd0);
    checks++;
    if (rx !== r) begin errors++;
      $display("FAIL m0_rx got %h exp %h", rx, r); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++;
      $display("FAIL m0_pulse got %b exp 0", done); end
    repeat (5) @(negedge clk);
    checks++;
    if (rx !== r) begin errors++;
      $display("FAIL m0_hold got %h exp %h", rx, r); end
  endtask

  task automatic test_mode3();
    int a, d; bit t; logic [7:0] r;
    @(negedge clk); mode = SMODE3;
    @(negedge clk);
    checks++;
    if (SCLK !== 1'b1) begin errors++;
      $display("FAIL m3_idle got %b exp 1", SCLK); end
    start_xfer(SMODE3, 8'h3C, 2'd3, a);
    wait_done(d, t);
    checks++;
    if (t || d - a !== LAT) begin errors++;
      $display("FAIL m3_lat got %0d exp %0d", d - a, LAT); end
    checks++;
    if (mon_byte !== 8'h3C) begin errors++;
      $display("FAIL m3_mosi got %h exp 3c", mon_byte); end
    checks++;
    if (mon_tog !== 16) begin errors++;
      $display("FAIL m3_tog got %0d exp 16", mon_tog); end
    checks++;
    if (mon_ss !== 18 * D) begin errors++;
      $display("FAIL m3_ss got %0d exp %0d", mon_ss, 18 * D); end
    r = exp_rx(8'h3C, 2'd3);
    checks++;
    if (rx !== r) begin errors++;
      $display("FAIL m3_rx got %h exp %h", rx, r); end
    checks++;
    if (SCLK !== 1'b1) begin errors++;
      $display("FAIL m3_end got %b exp 1", SCLK); end
  endtask

  task automatic test_back_to_back();
    int a1, a2, d1, d2; bit t; logic [7:0] r;
    @(negedge clk);
    mode = SMODE1; tx = 8'hC3; msel = 2'd0;
    mon_cpha = 1'b1; mon_tog = 0; mon_ss = 0; mon_byte = 8'h00;
    start = 1'b1;
    @(negedge clk);
    a1 = cyc;
    mode = SMODE2; tx = 8'h96;
    wait_done(d1, t);
    checks++;
    if (t || d1 - a1 !== LAT) begin errors++;
      $display("FAIL b2b1_lat got %0d exp %0d", d1 - a1, LAT); end
    checks++;
    if (mon_byte !== 8'hC3 || mon_tog !== 16) begin errors++;
      $display("FAIL b2b1_bus got %h/%0d exp c3/16",
               mon_byte, mon_tog); end
    r = exp_rx(8'hC3, 2'd0);
    checks++;
    if (rx !== r) begin errors++;
      $display("FAIL b2b1_rx got %h exp %h", rx, r); end
    checks++;
    if (ready !== 1'b1) begin errors++;
      $display("FAIL b2b_rdy got %b exp 1", ready); end
    mon_cpha = 1'b0; mon_tog = 0; mon_ss = 0; mon_byte = 8'h00;
    @(negedge clk);
    a2 = cyc;
    checks++;
    if (a2 - d1 !== 1 || ready !== 1'b0) begin errors++;
      $display("FAIL b2b_gap got %0d/%b exp 1/0", a2 - d1, ready); end
    start = 1'b0;
    wait_done(d2, t);
    checks++;
    if (t || d2 - a2 !== LAT) begin errors++;
      $display("FAIL b2b2_lat got %0d exp %0d", d2 - a2, LAT); end
    checks++;
    if (mon_byte !== 8'h96 || mon_tog !== 16) begin errors++;
      $display("FAIL b2b2_bus got %h/%0d exp 96/16",
               mon_byte, mon_tog); end
    r = exp_rx(8'h96, 2'd0);
    checks++;
    if (rx !== r || SCLK !== 1'b1) begin errors++;
      $display("FAIL b2b2_rx got %h/%b exp %h/1", rx, SCLK, r); end
  endtask

  task automatic test_ignore_start();
    int a, d, extra; bit t; logic [7:0] r;
    start_xfer(SMODE0, 8'h5A, 2'd1, a);
    repeat (6 * D) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++;
      $display("FAIL ign_busy got %b exp 0", ready); end
    start = 1'b1; tx = 8'hFF; mode = SMODE3;
    @(negedge clk);
    start = 1'b0;
    wait_done(d, t);
    checks++;
    if (t || d - a !== LAT) begin errors++;
      $display("FAIL ign_lat got %0d exp %0d", d - a, LAT); end
    checks++;
    if (mon_byte !== 8'h5A || mon_tog !== 16) begin errors++;
      $display("FAIL ign_bus got %h/%0d exp 5a/16",
               mon_byte, mon_tog); end
    r = exp_rx(8'h5A, 2'd1);
    checks++;
    if (rx !== r) begin errors++;
      $display("FAIL ign_rx got %h exp %h", rx, r); end
    extra = 0;
    repeat (30 * D) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++;
      $display("FAIL ign_done got %0d exp 0", extra); end
  endtask

  task automatic test_random();
    int a, d; bit t; spi_mode_e m;
    logic [7:0] b, r; logic [1:0] s;
    for (int i = 0; i < 8; i++) begin
      m = spi_mode_e'($urandom_range(0, 3));
      b = 8'($urandom);
      s = 2'($urandom_range(0, 3));
      start_xfer(m, b, s, a);
      wait_done(d, t);
      r = exp_rx(b, s);
      checks++;
      if (t || d - a !== LAT) begin errors++;
        $display("FAIL rnd%0d_lat got %0d exp %0d", i, d - a, LAT); end
      checks++;
      if (mon_byte !== b || mon_tog !== 16) begin errors++;
        $display("FAIL rnd%0d_bus got %h/%0d exp %h/16",
                 i, mon_byte, mon_tog, b); end
      checks++;
      if (rx !== r) begin errors++;
        $display("FAIL rnd%0d_rx got %h exp %h", i, rx, r); end
    end
  endtask

  task automatic test_reset_abort();
    int a, d, n, extra; bit t; logic [7:0] r;
    start_xfer(SMODE0, 8'hE7, 2'd3, a);
    n = 0;
    while (mon_tog < 7 && n < 20 * D) begin
      @(negedge clk); n++;
    end
    checks++;
    if (mon_tog !== 7) begin errors++;
      $display("FAIL abt_tog got %0d exp 7", mon_tog); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (SS !== 1'b1 || SCLK !== 1'b0) begin errors++;
      $display("FAIL abt_bus got %b%b exp 10", SS, SCLK); end
    checks++;
    if (done !== 1'b0 || rx !== 8'h00) begin errors++;
      $display("FAIL abt_out got %b/%h exp 0/00", done, rx); end
    mode = SMODE2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (30 * D) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || ready !== 1'b1) begin errors++;
      $display("FAIL abt_idle got %0d/%b exp 0/1", extra, ready); end
    checks++;
    if (SCLK !== 1'b1) begin errors++;
      $display("FAIL abt_cpol got %b exp 1", SCLK); end
    start_xfer(SMODE0, 8'h81, 2'd0, a);
    wait_done(d, t);
    r = exp_rx(8'h81, 2'd0);
    checks++;
    if (t || d - a !== LAT) begin errors++;
      $display("FAIL abt2_lat got %0d exp %0d", d - a, LAT); end
    checks++;
    if (mon_byte !== 8'h81 || mon_tog !== 16) begin errors++;
      $display("FAIL abt2_bus got %h/%0d exp 81/16",
               mon_byte, mon_tog); end
    checks++;
    if (rx !== r) begin errors++;
      $display("FAIL abt2_rx got %h exp %h", rx, r); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got stall exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0_loop();
    test_mode3();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per SCLK half-period; legal range 2..255.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port M_STATE  input  spi_mode_e  SPI mode SMODE0..SMODE3 (CPOL = mode bit 1, CPHA = mode bit 0).
REQ-005 SHALL have port start  input  1  request one 8-bit transfer; accepted only while ready=1.
REQ-006 SHALL have port tx_data  input  8  byte to send, MSB first, captured on acceptance.
REQ-007 SHALL have port ready  output  1  high only in IDLE.
REQ-008 SHALL have port done  output  1  single-cycle pulse at transfer end.
REQ-009 SHALL have port rx_data  output  8  last byte received on MISO.
REQ-010 SHALL have ports SCLK output 1, MOSI output 1, SS output 1 (active-low select), MISO input 1.

Function
REQ-011 SHALL implement states IDLE, SETUP, TRANSFER, HOLD, DONE.
REQ-012 IDLE: SS=1, MOSI=0, SCLK=CPOL of live M_STATE (registered), ready=1; start=1 -> SETUP next edge.
REQ-013 On acceptance SHALL latch tx_data into the shift register and latch M_STATE; later changes of either SHALL NOT affect the transfer.
REQ-014 SETUP: SS=0, MOSI=bit 7, SCLK at CPOL, lasts exactly CLK_DIV cycles, then TRANSFER.
REQ-015 TRANSFER: SCLK SHALL toggle every CLK_DIV cycles, exactly 16 toggles, ending at CPOL level.
REQ-016 CPHA=0: MISO sampled on odd (leading) toggles; shift register shifts left, MOSI updated to next bit on even (trailing) toggles except the 16th.
REQ-017 CPHA=1: MOSI updated on odd (leading) toggles (first toggle presents bit 7); MISO sampled on even (trailing) toggles.
REQ-018 Sampled MISO bits SHALL enter LSB of the receive register; after 8 samples register holds received byte MSB-first.
REQ-019 HOLD: SS=0, SCLK=CPOL, lasts CLK_DIV cycles, then DONE.
REQ-020 DONE: SS=1, done=1 for one cycle, rx_data updated from receive register, then IDLE.
REQ-021 done SHALL rise exactly 18*CLK_DIV+1 cycles after the edge accepting start.
REQ-022 start while ready=0 SHALL be ignored (not queued); start held high in IDLE after DONE SHALL begin a new transfer immediately.
REQ-023 rx_data SHALL hold its value between DONE pulses.
REQ-024 Divider counter and bit counter SHALL be cleared on entry to SETUP.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, SS=1, SCLK=0, MOSI=0, done=0, rx_data=0x00, counters and shift registers 0; ready=1 after reset.
REQ-026 Reset mid-transfer SHALL abort without done pulse; SS deasserts immediately.
REQ-027 After reset release, SCLK SHALL take live CPOL within one cycle.

Configuration
REQ-028 Macro SPI_MASTER_RX_EN defined: MISO sampling and rx_data per REQ-016..020.
REQ-029 Macro SPI_MASTER_RX_EN undefined: receive logic omitted, MISO ignored, rx_data constant 0x00; timing unchanged.

Structure
REQ-030 spi_mode_e (SMODE0..SMODE3) SHALL come from shared spi_mode_pkg; state enum local to module.
REQ-031 SHALL instantiate one sub-module spi_master_clkgen: divider counter producing SCLK level plus one-cycle leading/trailing toggle strobes and a toggle count.

Verification
REQ-032 SMODE0, CLK_DIV=4, tx_data=0xA5, MISO looped to MOSI -> MOSI bits 1,0,1,0,0,1,0,1 stable at each rising SCLK, rx_data=0xA5, done at cycle 73.
REQ-033 SMODE3, tx_data=0x3C, MISO tied 1 -> SCLK idles 1, 16 toggles, rx_data=0xFF, SS low for 18*CLK_DIV cycles.
REQ-034 SMODE1 then SMODE2 back-to-back, start held high -> second SETUP begins cycle after done; each transfer uses its own latched mode.
REQ-035 start pulsed during TRANSFER, tx_data changed -> ignored; transmitted byte unchanged, one done only.
REQ-036 reset=0 at toggle 7 -> SS=1, SCLK=0, no done, rx_data=0x00; next transfer with 0x81 completes correctly.
REQ-037 SPI_MASTER_RX_EN undefined, MISO toggling -> rx_data stays 0x00, done timing identical to REQ-032.
